// File: rtl/orb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : orb_pkg                                                    |
// | Description : Shared types and defaults for the frame-read front end of  |
// |               the corner-detection pipeline: traversal directions, the   |
// |               fetch FSM state encoding and default image/pixel sizes.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package orb_pkg;

  // Default image limits and pixel width
  localparam int X_MAX_DEF = 300;
  localparam int Y_MAX_DEF = 300;
  localparam int PIX_W_DEF = 8;

  // Traversal step direction. Bit 1 set means "moves to the next row".
  typedef enum logic [1:0] {
    DIR_RIGHT    = 2'b00,
    DIR_LEFT     = 2'b01,
    DIR_DOWN     = 2'b10,  // next row, x kept (serpentine)
    DIR_DOWN_RET = 2'b11   // next row, x back to 0 (raster)
  } dir_e;

  // Fetch engine states
  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_START = 3'd1,
    FS_REQ   = 3'd2,
    FS_WAIT  = 3'd3,
    FS_OUT   = 3'd4,
    FS_ADV   = 3'd5,
    FS_DONE  = 3'd6
  } fetch_state_e;

endpackage : orb_pkg
`default_nettype wire

// File: rtl/pixel_pos.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pixel_pos                                                  |
// | Description : Image traversal generator. Walks (x,y) over a frame of    |
// |               (max_x+1) x (max_y+1) pixels in raster or serpentine order |
// |               and reports the direction of the next step.               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk         in   clock                                                 |
// |   n_rst       in   asynchronous active-low reset                         |
// |   new_trans   in   restart traversal at (0,0)                            |
// |   update_pos  in   take one step; new position visible next cycle        |
// |   max_x/max_y in   last column / last row index                          |
// |   curr_x/y    out  current position                                      |
// |   end_pos     out  current position is the last of the frame             |
// |   next_dir    out  direction the next update_pos will move               |
// +--------------------------------------------------------------------------+
module pixel_pos
  import orb_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF,
  parameter int MODE  = 1,
  localparam int XW   = $clog2(X_MAX),
  localparam int YW   = $clog2(Y_MAX)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          new_trans,
  input  logic          update_pos,
  input  logic [XW-1:0] max_x,
  input  logic [YW-1:0] max_y,
  output logic [XW-1:0] curr_x,
  output logic [YW-1:0] curr_y,
  output logic          end_pos,
  output dir_e          next_dir
);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          left_q;   // serpentine: current row is walked right-to-left
  logic          row_end;

  always_comb begin
    row_end  = 1'b0;
    next_dir = DIR_RIGHT;
    if (MODE != 0) begin
      row_end  = left_q ? (x_q == '0) : (x_q == max_x);
      next_dir = row_end ? DIR_DOWN : (left_q ? DIR_LEFT : DIR_RIGHT);
    end else begin
      row_end  = (x_q == max_x);
      next_dir = row_end ? DIR_DOWN_RET : DIR_RIGHT;
    end
    end_pos = row_end && (y_q == max_y);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_q    <= '0;
      y_q    <= '0;
      left_q <= 1'b0;
    end else if (new_trans) begin
      x_q    <= '0;
      y_q    <= '0;
      left_q <= 1'b0;
    end else if (update_pos) begin
      case (next_dir)
        DIR_RIGHT: x_q <= x_q + XW'(1);
        DIR_LEFT:  x_q <= x_q - XW'(1);
        DIR_DOWN: begin
          y_q    <= y_q + YW'(1);
          left_q <= ~left_q;
        end
        default: begin
          y_q <= y_q + YW'(1);
          x_q <= '0;
        end
      endcase
    end
  end

  assign curr_x = x_q;
  assign curr_y = y_q;

endmodule : pixel_pos
`default_nettype wire

// File: rtl/pixel_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pixel_fetch                                                |
// | Description : Frame read engine. Walks the image with pixel_pos, reads  |
// |               each pixel from SRAM and hands it downstream one pixel per |
// |               valid/ready handshake, stepping only after acceptance.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, n_rst            clock, asynchronous active-low reset            |
// |   start                 begin a frame (only honoured when idle)         |
// |   max_x, max_y          last column / row index, stable while busy      |
// |   busy, frame_done      engine active / one-cycle end-of-frame pulse    |
// |   mem_ren, mem_addr     SRAM read strobe and address                    |
// |   mem_rdata, mem_rvalid SRAM read return (latency >= 1)                 |
// |   pix_valid, pix_ready  downstream handshake                            |
// |   pix_data/x/y/last     pixel value, position and end-of-frame flag     |
// +--------------------------------------------------------------------------+
module pixel_fetch
  import orb_pkg::*;
#(
  parameter int X_MAX  = X_MAX_DEF,
  parameter int Y_MAX  = Y_MAX_DEF,
  parameter int MODE   = 1,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = $clog2(X_MAX * Y_MAX),
  localparam int XW    = $clog2(X_MAX),
  localparam int YW    = $clog2(Y_MAX)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [XW-1:0]     max_x,
  input  logic [YW-1:0]     max_y,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  input  logic              mem_rvalid,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic              pix_last
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [PIX_W-1:0]  pix_data_q;
  logic [XW-1:0]     pix_x_q;
  logic [YW-1:0]     pix_y_q;
  logic              pix_last_q;

  logic              new_trans;
  logic              update_pos;
  logic [XW-1:0]     curr_x;
  logic [YW-1:0]     curr_y;
  logic              end_pos;
  dir_e              next_dir;
  logic [ADDR_W-1:0] row_step;
  logic              step_down;

  pixel_pos #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX),
    .MODE  (MODE)
  ) u_pixel_pos (
    .clk        (clk),
    .n_rst      (n_rst),
    .new_trans  (new_trans),
    .update_pos (update_pos),
    .max_x      (max_x),
    .max_y      (max_y),
    .curr_x     (curr_x),
    .curr_y     (curr_y),
    .end_pos    (end_pos),
    .next_dir   (next_dir)
  );

  // Strobes are pure decodes of the state register, so they carry no
  // combinational path from any input.
  assign new_trans  = (state_q == FS_START);
  assign update_pos = (state_q == FS_ADV);
  assign mem_ren    = (state_q == FS_REQ);
  assign pix_valid  = (state_q == FS_OUT);
  assign frame_done = (state_q == FS_DONE);
  assign busy       = (state_q != FS_IDLE);

  // Linear address without a multiplier: row_base tracks y*(max_x+1)
  // and is bumped by one row stride on every downward step.
  assign row_step  = ADDR_W'(max_x) + ADDR_W'(1);
  assign step_down = (next_dir == DIR_DOWN) || (next_dir == DIR_DOWN_RET);
  assign mem_addr  = row_base_q + ADDR_W'(curr_x);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= FS_IDLE;
      row_base_q <= '0;
      pix_data_q <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      pix_last_q <= 1'b0;
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (start) state_q <= FS_START;
        end
        FS_START: begin
          row_base_q <= '0;
          state_q    <= FS_REQ;
        end
        FS_REQ: begin
          // Position is captured with the request so it stays attached to
          // this pixel while pixel_pos is later advanced.
          pix_x_q    <= curr_x;
          pix_y_q    <= curr_y;
          pix_last_q <= end_pos;
          state_q    <= FS_WAIT;
        end
        FS_WAIT: begin
          if (mem_rvalid) begin
            pix_data_q <= mem_rdata;
            state_q    <= FS_OUT;
          end
        end
        FS_OUT: begin
          if (pix_ready) state_q <= pix_last_q ? FS_DONE : FS_ADV;
        end
        FS_ADV: begin
          // next_dir still describes the move update_pos is making now
          if (step_down) row_base_q <= row_base_q + row_step;
          state_q <= FS_REQ;
        end
        FS_DONE: begin
          state_q <= FS_IDLE;
        end
        default: begin
          state_q <= FS_IDLE;
        end
      endcase
    end
  end

  assign pix_data = pix_data_q;
  assign pix_x    = pix_x_q;
  assign pix_y    = pix_y_q;
  assign pix_last = pix_last_q;

endmodule : pixel_fetch
`default_nettype wire

// File: tb/tb_pixel_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pixel_fetch                                             |
// | Description : Scoreboard bench for pixel_fetch. Serpentine and raster   |
// |               instances share an SRAM model; expected addresses and      |
// |               pixels are queued by the stimulus and popped by a monitor. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pixel_fetch;

  localparam int XW = 9;
  localparam int YW = 9;
  localparam int AW = 17;
  localparam int PW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last;
  } pix_t;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start_s, start_r;
  logic [XW-1:0] max_x;
  logic [YW-1:0] max_y;
  logic          pix_ready;
  logic [PW-1:0] mem_rdata;
  logic          mem_rvalid;

  logic          s_busy, s_done, s_ren, s_pv, s_pl;
  logic [AW-1:0] s_addr;
  logic [PW-1:0] s_pd;
  logic [XW-1:0] s_px;
  logic [YW-1:0] s_py;
  logic          q_busy, q_done, q_ren, q_pv, q_pl;
  logic [AW-1:0] q_addr;
  logic [PW-1:0] q_pd;
  logic [XW-1:0] q_px;
  logic [YW-1:0] q_py;

  logic          sel;  // 1: serpentine instance observed, 0: raster
  logic          m_busy, m_done, m_ren, m_pv, m_pl;
  logic [AW-1:0] m_addr;
  logic [PW-1:0] m_pd;
  logic [XW-1:0] m_px;
  logic [YW-1:0] m_py;

  int   total = 0;
  int   bad   = 0;
  int   ren_cnt = 0;
  int   done_cnt = 0;
  int   acc_cnt = 0;
  int   lat;
  int   stall_at;
  logic glitch_en;

  logic [AW-1:0] exp_addr[$];
  pix_t          exp_pix[$];

  int serp_x[9] = '{0, 1, 2, 2, 1, 0, 0, 1, 2};
  int serp_y[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

  always #5 clk = ~clk;

  pixel_fetch #(.X_MAX(300), .Y_MAX(300), .MODE(1), .PIX_W(PW)) dut_s (
    .clk(clk), .n_rst(n_rst), .start(start_s), .max_x(max_x), .max_y(max_y),
    .busy(s_busy), .frame_done(s_done), .mem_ren(s_ren), .mem_addr(s_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .pix_valid(s_pv),
    .pix_ready(pix_ready), .pix_data(s_pd), .pix_x(s_px), .pix_y(s_py),
    .pix_last(s_pl)
  );

  pixel_fetch #(.X_MAX(300), .Y_MAX(300), .MODE(0), .PIX_W(PW)) dut_r (
    .clk(clk), .n_rst(n_rst), .start(start_r), .max_x(max_x), .max_y(max_y),
    .busy(q_busy), .frame_done(q_done), .mem_ren(q_ren), .mem_addr(q_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .pix_valid(q_pv),
    .pix_ready(pix_ready), .pix_data(q_pd), .pix_x(q_px), .pix_y(q_py),
    .pix_last(q_pl)
  );

  assign m_busy = sel ? s_busy : q_busy;
  assign m_done = sel ? s_done : q_done;
  assign m_ren  = sel ? s_ren  : q_ren;
  assign m_addr = sel ? s_addr : q_addr;
  assign m_pv   = sel ? s_pv   : q_pv;
  assign m_pd   = sel ? s_pd   : q_pd;
  assign m_px   = sel ? s_px   : q_px;
  assign m_py   = sel ? s_py   : q_py;
  assign m_pl   = sel ? s_pl   : q_pl;

  // SRAM contents
  function automatic logic [PW-1:0] mem_fn(input logic [AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd13 + 32'd7;
    return t[PW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string name);
    chk(name, {m_busy, m_done, m_ren, m_addr, m_pv, m_pd, m_px, m_py, m_pl}, 64'd0);
  endtask

  task automatic push_pix(input int a, input int x, input int y, input bit last, input bit with_pix);
    pix_t p;
    exp_addr.push_back(AW'(a));
    p.addr = AW'(a);
    p.x    = XW'(x);
    p.y    = YW'(y);
    p.last = last;
    if (with_pix) exp_pix.push_back(p);
  endtask

  task automatic load_serp();
    for (int i = 0; i < 9; i++)
      push_pix(serp_y[i] * 3 + serp_x[i], serp_x[i], serp_y[i], i == 8, 1'b1);
  endtask

  task automatic load_rast();
    for (int i = 0; i < 9; i++)
      push_pix(i, i % 3, i / 3, i == 8, 1'b1);
  endtask

  // SRAM model: a read seen in cycle t returns data in cycle t+lat.
  // With glitch_en, a spurious rvalid with junk data is driven while the
  // observed instance presents a pixel.
  initial begin : g_sram
    int            cnt;
    logic [AW-1:0] paddr;
    cnt = 0;
    paddr = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (n_rst && m_ren) begin
        cnt   = lat;
        paddr = m_addr;
      end
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (!n_rst) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_fn(paddr);
        end
      end
      if (!mem_rvalid && glitch_en && m_pv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 8'hEE;
      end
    end
  end

  // Monitor: pops expectations on every read strobe and accepted pixel,
  // and checks that a stalled pixel holds steady.
  initial begin : g_monitor
    pix_t                e;
    logic                hold_prev;
    logic [PW+XW+YW:0]   snap;
    hold_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        hold_prev = 1'b0;
      end else begin
        if (m_ren) begin
          ren_cnt++;
          if (exp_addr.size() == 0) chk("unexpected_ren", 64'(m_addr), 64'hFFFF_FFFF);
          else chk("mem_addr", 64'(m_addr), 64'(exp_addr.pop_front()));
        end
        if (hold_prev) begin
          chk("hold_valid", 64'(m_pv), 64'd1);
          chk("hold_outputs", 64'({m_pd, m_px, m_py, m_pl}), 64'(snap));
        end
        hold_prev = m_pv && !pix_ready;
        snap = {m_pd, m_px, m_py, m_pl};
        if (m_pv && pix_ready) begin
          acc_cnt++;
          if (exp_pix.size() == 0) begin
            chk("unexpected_pixel", 64'(m_px), 64'hFFFF_FFFF);
          end else begin
            e = exp_pix.pop_front();
            chk("pix_data", 64'(m_pd), 64'(mem_fn(e.addr)));
            chk("pix_x", 64'(m_px), 64'(e.x));
            chk("pix_y", 64'(m_py), 64'(e.y));
            chk("pix_last", 64'(m_pl), 64'(e.last));
          end
        end
        if (m_done) done_cnt++;
      end
    end
  end

  task automatic run_frame(input int exp_done, input int exp_ren);
    int cyc, stall_left, ren0, d0;
    bit stalled;
    ren0 = ren_cnt;
    d0 = done_cnt;
    acc_cnt = 0;
    stall_left = 0;
    stalled = 0;
    if (sel) start_s = 1'b1; else start_r = 1'b1;
    tick();
    start_s = 1'b0;
    start_r = 1'b0;
    cyc = 1;
    chk("start_busy", 64'(m_busy), 64'd1);
    chk("start_no_ren", 64'(m_ren), 64'd0);
    tick();
    cyc = 2;
    chk("first_ren", 64'(m_ren), 64'd1);
    chk("first_addr", 64'(m_addr), 64'd0);
    while (!m_done && cyc < exp_done + 20) begin
      tick();
      cyc++;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) pix_ready = 1'b1;
      end
      if (stall_at >= 0 && !stalled && m_pv && acc_cnt == stall_at) begin
        pix_ready  = 1'b0;
        stall_left = 5;
        stalled    = 1;
      end
    end
    chk("done_cycle", 64'(cyc), 64'(exp_done));
    chk("busy_at_done", 64'(m_busy), 64'd1);
    tick();
    chk("busy_after_done", 64'(m_busy), 64'd0);
    chk("ren_count", 64'(ren_cnt - ren0), 64'(exp_ren));
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("queues_empty", 64'(exp_addr.size() + exp_pix.size()), 64'd0);
  endtask

  task automatic reset_test();
    int cyc, ren0, d0;
    for (int i = 0; i < 4; i++)
      push_pix(serp_y[i] * 3 + serp_x[i], serp_x[i], serp_y[i], 1'b0, 1'b1);
    push_pix(4, 1, 1, 1'b0, 1'b0);  // pixel 4 is read but never delivered
    ren0 = ren_cnt;
    d0 = done_cnt;
    acc_cnt = 0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cyc = 1;
    while (!(m_pv && acc_cnt == 4) && cyc < 60) begin
      tick();
      cyc++;
      start_s = (cyc == 10);  // must be ignored while busy
    end
    start_s = 1'b0;
    chk("pix4_cycle", 64'(cyc), 64'd20);
    n_rst = 1'b0;
    #1;
    chk_reset("midframe_rst_outputs");
    tick();
    tick();
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_ren_count", 64'(ren_cnt - ren0), 64'd5);
    chk("rst_accepted", 64'(acc_cnt), 64'd4);
    chk("rst_queues", 64'(exp_addr.size() + exp_pix.size()), 64'd0);
    n_rst = 1'b1;
    tick();
  endtask

  initial begin : g_stim
    n_rst = 1'b0;
    start_s = 1'b0;
    start_r = 1'b0;
    pix_ready = 1'b1;
    max_x = 2;
    max_y = 2;
    sel = 1'b1;
    lat = 1;
    glitch_en = 1'b0;
    stall_at = -1;
    repeat (3) tick();
    chk_reset("reset_outputs_serp");
    sel = 1'b0;
    #1;
    chk_reset("reset_outputs_rast");
    sel = 1'b1;
    n_rst = 1'b1;
    tick();

    // serpentine 3x3, L=1, ready high: 4 cycles per pixel
    load_serp();
    run_frame(37, 9);

    // raster 3x3
    sel = 1'b0;
    load_rast();
    run_frame(37, 9);

    // backpressure on pixel 3 for 5 cycles
    sel = 1'b1;
    stall_at = 3;
    load_serp();
    run_frame(42, 9);

    // L=3 with spurious rvalid during OUT, plus a stall to expose capture
    sel = 1'b0;
    lat = 3;
    glitch_en = 1'b1;
    stall_at = 2;
    load_rast();
    run_frame(60, 9);
    glitch_en = 1'b0;
    lat = 1;
    stall_at = -1;

    // ignored start, then reset at pixel 4
    sel = 1'b1;
    reset_test();

    // 1x1 frame, also a restart at address 0 after reset
    max_x = 0;
    max_y = 0;
    push_pix(0, 0, 0, 1'b1, 1'b1);
    run_frame(5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : g_timeout
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule : tb_pixel_fetch
`default_nettype wire
